entry_input_conditioner: RTL and testbench

//  Front end of the pass-entry path. Takes the raw board inputs (4 data switches, confirm button,

---
 rtl/entry_pkg.sv | 14 +
 rtl/entry_input_conditioner_debounce.sv | 42 ++++
 rtl/entry_input_conditioner.sv | 103 ++++++++++
 tb/tb_entry_input_conditioner.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/entry_pkg.sv
// Shared definitions for the pass-entry input conditioner: button FSM encoding,
// default timing constants and the pass-code width.
package entry_pkg;

   typedef enum logic {
      RELEASED = 1'b0,
      PRESSED  = 1'b1
   } btn_state_t;

   localparam int DEF_SYNC_STAGES     = 2;
   localparam int DEF_DEBOUNCE_CYCLES = 16;
   localparam int PASS_W              = 4;

endpackage

// File: rtl/entry_input_conditioner_debounce.sv
// Synchroniser plus debounce filter for one bouncing board input.
// The committed level only moves after the synced input disagrees with it for DEBOUNCE_CYCLES cycles.
module debounce_filter
   import entry_pkg::*;
#(
   parameter int SYNC_STAGES     = DEF_SYNC_STAGES,
   parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
   input  logic clk,
   input  logic reset,
   input  logic din,
   output logic level
);

   localparam int CNT_W = $clog2(DEBOUNCE_CYCLES) + 1;

   logic [SYNC_STAGES-1:0] sync_q;
   logic [CNT_W-1:0]       cnt;
   logic                   din_sync;

   assign din_sync = sync_q[SYNC_STAGES-1];

   // Counter is cleared on commit so it can never wrap.
   always_ff @(posedge clk) begin
      if (reset) begin
         sync_q <= '0;
         cnt    <= '0;
         level  <= 1'b0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], din};
         if (din_sync == level) begin
            cnt <= '0;
         end else if (cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
            level <= din_sync;
            cnt   <= '0;
         end else begin
            cnt <= cnt + CNT_W'(1);
         end
      end
   end

endmodule

// File: rtl/entry_input_conditioner.sv
// Front end of the pass-entry path: synchronises and debounces the board inputs and turns
// a debounced button press into a one-cycle confirm (or reject) with a snapshot of the switches.
module entry_input_conditioner
   import entry_pkg::*;
#(
   parameter int SYNC_STAGES     = DEF_SYNC_STAGES,
   parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [PASS_W-1:0] sw_data,
   input  logic              btn_confirm,
   input  logic              sw_enable,
   output logic [PASS_W-1:0] pass_data,
   output logic              confirm,
   output logic              enable,
   output logic              reject
);

   localparam int CNT_W = $clog2(DEBOUNCE_CYCLES) + 1;

   logic                               btn_lvl;
   logic [SYNC_STAGES-1:0][PASS_W-1:0] data_sync_q;
   logic [PASS_W-1:0]                  data_sync;
   logic [PASS_W-1:0]                  data_prev;
   logic [CNT_W-1:0]                   stab_cnt;
   logic                               data_stable;
   btn_state_t                         state;

   debounce_filter #(
      .SYNC_STAGES     (SYNC_STAGES),
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
   ) u_btn_filter (
      .clk   (clk),
      .reset (reset),
      .din   (btn_confirm),
      .level (btn_lvl)
   );

   debounce_filter #(
      .SYNC_STAGES     (SYNC_STAGES),
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
   ) u_enable_filter (
      .clk   (clk),
      .reset (reset),
      .din   (sw_enable),
      .level (enable)
   );

   assign data_sync = data_sync_q[SYNC_STAGES-1];

   // A change landing in the commit cycle itself must also count as unstable.
   assign data_stable = (stab_cnt == CNT_W'(DEBOUNCE_CYCLES)) && (data_sync == data_prev);

   // Switch synchroniser and saturating stability counter.
   always_ff @(posedge clk) begin
      if (reset) begin
         data_sync_q <= '0;
         data_prev   <= '0;
         stab_cnt    <= '0;
      end else begin
         data_sync_q <= {data_sync_q[SYNC_STAGES-2:0], sw_data};
         data_prev   <= data_sync;
         if (data_sync != data_prev) begin
            stab_cnt <= '0;
         end else if (stab_cnt != CNT_W'(DEBOUNCE_CYCLES)) begin
            stab_cnt <= stab_cnt + CNT_W'(1);
         end
      end
   end

   // Button FSM; enable here is the registered level from before this edge's update.
   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= RELEASED;
         confirm   <= 1'b0;
         reject    <= 1'b0;
         pass_data <= '0;
      end else begin
         confirm <= 1'b0;
         reject  <= 1'b0;
         case (state)
            RELEASED: begin
               if (btn_lvl) begin
                  state <= PRESSED;
                  if (enable && data_stable) begin
                     confirm   <= 1'b1;
                     pass_data <= data_sync;
                  end else begin
                     reject <= 1'b1;
                  end
               end
            end
            PRESSED: begin
               if (!btn_lvl) begin
                  state <= RELEASED;
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_entry_input_conditioner.sv
// Directed bench for entry_input_conditioner (SYNC_STAGES=2, DEBOUNCE_CYCLES=4, press latency 7).
// Expected pulses are queued when a press is driven and matched by a monitor when the DUT pulses.
module tb_entry_input_conditioner;

   localparam int LAT = 7;

   typedef struct {
      logic       is_confirm;
      logic [3:0] data;
      int         cycle;
   } exp_t;

   logic       clk;
   logic       reset;
   logic [3:0] sw_data;
   logic       btn_confirm;
   logic       sw_enable;
   logic [3:0] pass_data;
   logic       confirm;
   logic       enable;
   logic       reject;

   int   checks = 0;
   int   errors = 0;
   int   cyc    = 0;
   int   t0;
   exp_t sb[$];
   exp_t mon_e;

   entry_input_conditioner #(
      .SYNC_STAGES     (2),
      .DEBOUNCE_CYCLES (4)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .sw_data     (sw_data),
      .btn_confirm (btn_confirm),
      .sw_enable   (sw_enable),
      .pass_data   (pass_data),
      .confirm     (confirm),
      .enable      (enable),
      .reject      (reject)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic applyStimulus(input logic rst, input logic [3:0] data, input logic btn,
                                input logic en);
      reset       = rst;
      sw_data     = data;
      btn_confirm = btn;
      sw_enable   = en;
   endtask

   task automatic waitClocks(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic expectPulse(input logic is_confirm, input logic [3:0] data);
      exp_t e;
      e.is_confirm = is_confirm;
      e.data       = data;
      e.cycle      = cyc + LAT;
      sb.push_back(e);
   endtask

   // Scoreboard monitor: every pulse must match the head of the queue, on time.
   always @(negedge clk) begin
      if (confirm || reject) begin
         checkOutput("pulse_exclusive", 32'(confirm & reject), 32'd0);
         if (sb.size() == 0) begin
            checkOutput("unexpected_pulse", {30'd0, confirm, reject}, 32'd0);
         end else begin
            mon_e = sb.pop_front();
            checkOutput("pulse_kind", 32'(confirm), 32'(mon_e.is_confirm));
            checkOutput("pulse_cycle", 32'(cyc), 32'(mon_e.cycle));
            checkOutput("pulse_pass_data", 32'(pass_data), 32'(mon_e.data));
         end
      end else if (sb.size() != 0 && sb[0].cycle <= cyc) begin
         mon_e = sb.pop_front();
         checkOutput("missing_pulse", {30'd0, confirm, reject},
                     mon_e.is_confirm ? 32'd2 : 32'd1);
      end
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      // 1: reset with button and enable held, then enable debounce after release
      applyStimulus(1'b1, 4'b0000, 1'b1, 1'b1);
      waitClocks(3);
      checkOutput("reset_confirm", 32'(confirm), 32'd0);
      checkOutput("reset_reject", 32'(reject), 32'd0);
      checkOutput("reset_enable", 32'(enable), 32'd0);
      checkOutput("reset_pass_data", 32'(pass_data), 32'd0);
      applyStimulus(1'b0, 4'b0000, 1'b0, 1'b1);
      waitClocks(5);
      checkOutput("enable_pre_rise", 32'(enable), 32'd0);
      waitClocks(1);
      checkOutput("enable_rise", 32'(enable), 32'd1);

      // 2: clean press with stable data
      sw_data = 4'b1101;
      waitClocks(10);
      btn_confirm = 1'b1;
      expectPulse(1'b1, 4'b1101);
      waitClocks(20);
      btn_confirm = 1'b0;
      waitClocks(10);

      // 3: bouncing press, then short glitches that must be filtered
      btn_confirm = 1'b1; waitClocks(1);
      btn_confirm = 1'b0; waitClocks(1);
      btn_confirm = 1'b1; waitClocks(1);
      btn_confirm = 1'b0; waitClocks(1);
      btn_confirm = 1'b1;
      expectPulse(1'b1, 4'b1101);
      waitClocks(12);
      btn_confirm = 1'b0;
      waitClocks(10);
      for (int g = 0; g < 2; g++) begin
         btn_confirm = 1'b1; waitClocks(3);
         btn_confirm = 1'b0; waitClocks(5);
      end
      waitClocks(5);

      // 4: data changes just before the press commits
      sw_data = 4'b0110;
      waitClocks(10);
      btn_confirm = 1'b1;
      expectPulse(1'b0, 4'b1101);
      waitClocks(4);
      sw_data = 4'b0111;
      waitClocks(16);
      btn_confirm = 1'b0;
      waitClocks(10);
      checkOutput("pass_data_held", 32'(pass_data), 32'h0000_000d);

      // 5: press while disabled, then enabled
      sw_enable = 1'b0;
      waitClocks(8);
      checkOutput("enable_low", 32'(enable), 32'd0);
      btn_confirm = 1'b1;
      expectPulse(1'b0, 4'b1101);
      waitClocks(12);
      btn_confirm = 1'b0;
      waitClocks(10);
      sw_enable = 1'b1;
      waitClocks(8);
      checkOutput("enable_high", 32'(enable), 32'd1);
      btn_confirm = 1'b1;
      expectPulse(1'b1, 4'b0111);
      waitClocks(12);
      btn_confirm = 1'b0;
      waitClocks(10);

      // Enable falls on the same edge the FSM sees the press: old enable wins
      btn_confirm = 1'b1;
      expectPulse(1'b1, 4'b0111);
      waitClocks(1);
      sw_enable = 1'b0;
      waitClocks(5);
      checkOutput("enable_old_value", 32'(enable), 32'd1);
      waitClocks(1);
      checkOutput("enable_fell_at_commit", 32'(enable), 32'd0);
      waitClocks(6);
      btn_confirm = 1'b0;
      sw_enable   = 1'b1;
      waitClocks(10);

      // 6: reset mid-debounce with button held, then full re-debounce
      sw_data = 4'b0000;
      waitClocks(10);
      btn_confirm = 1'b1;
      waitClocks(4);
      reset = 1'b1;
      waitClocks(3);
      checkOutput("midreset_enable", 32'(enable), 32'd0);
      checkOutput("midreset_pass_data", 32'(pass_data), 32'd0);
      reset = 1'b0;
      t0 = cyc;
      expectPulse(1'b1, 4'b0000);
      waitClocks(5);
      checkOutput("post_reset_enable_low", 32'(enable), 32'd0);
      waitClocks(7);
      btn_confirm = 1'b0;
      waitClocks(12);

      checkOutput("scoreboard_empty", 32'(sb.size()), 32'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
